// File: rtl/oai22_arc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : oai22_seq_pkg
// Brief    : Shared types, constants and arc tables for the OAI22 arc sequencer
// Revision : 1.0 - initial release
// ============================================================================
package oai22_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FIN    = 2'd3
    } state_t;

    localparam int NUM_ARCS   = 12;
    localparam int NUM_PHASES = 3;

    localparam int PIN_A1 = 0;
    localparam int PIN_A2 = 1;
    localparam int PIN_B1 = 2;
    localparam int PIN_B2 = 3;

    localparam logic [3:0] FAIL_NONE = 4'hF;

    // Side-input values for each arc, listed in ascending pin order of the
    // three pins that are not being toggled.
    function automatic logic [2:0] side_cond(input logic [3:0] arc);
        logic [2:0] v;
        case (arc)
            4'd0:    v = 3'b001;
            4'd1:    v = 3'b010;
            4'd2:    v = 3'b011;
            4'd3:    v = 3'b001;
            4'd4:    v = 3'b010;
            4'd5:    v = 3'b011;
            4'd6:    v = 3'b010;
            4'd7:    v = 3'b100;
            4'd8:    v = 3'b110;
            4'd9:    v = 3'b010;
            4'd10:   v = 3'b100;
            4'd11:   v = 3'b110;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] arc_pin(input logic [3:0] arc);
        logic [1:0] p;
        if (arc < 4'd3)      p = 2'd0;
        else if (arc < 4'd6) p = 2'd1;
        else if (arc < 4'd9) p = 2'd2;
        else                 p = 2'd3;
        return p;
    endfunction

    // Drive vector is indexed by pin number.
    function automatic logic oai22_zn(input logic [3:0] d);
        return ~((d[PIN_A1] | d[PIN_A2]) & (d[PIN_B1] | d[PIN_B2]));
    endfunction

endpackage
`default_nettype wire

// File: rtl/oai22_arc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : oai22_arc_sequencer_if
// Brief    : Control, cell-drive and status bundle of the OAI22 arc sequencer
// Revision : 1.0 - initial release
// ============================================================================
interface oai22_arc_sequencer_if;
    logic       START;
    logic       ABORT;
    logic       ZN_I;
    logic       A1_O;
    logic       A2_O;
    logic       B1_O;
    logic       B2_O;
    logic       BUSY;
    logic       DONE;
    logic       PASS;
    logic [4:0] ERR_CNT;
    logic [3:0] FAIL_ARC;
    logic [3:0] ARC_IDX;

    modport master (
        output START, ABORT, ZN_I,
        input  A1_O, A2_O, B1_O, B2_O, BUSY, DONE, PASS, ERR_CNT, FAIL_ARC, ARC_IDX
    );

    modport slave (
        input  START, ABORT, ZN_I,
        output A1_O, A2_O, B1_O, B2_O, BUSY, DONE, PASS, ERR_CNT, FAIL_ARC, ARC_IDX
    );
endinterface
`default_nettype wire

// File: rtl/oai22_arc_sequencer_rom.sv
`default_nettype none
// ============================================================================
// Module   : oai22_arc_rom
// Brief    : Maps (arc, phase) to the cell drive pattern and its expected ZN
// Revision : 1.0 - initial release
// ============================================================================
module oai22_arc_rom
    import oai22_seq_pkg::*;
(
    input  wire logic [3:0] i_arc,
    input  wire logic [1:0] i_phase,
    output logic      [3:0] o_drive,
    output logic            o_exp_zn
);

    logic [2:0] w_side;
    logic       w_act;

    // Drive bit order is {B2, B1, A2, A1}; the active pin goes 0, 1, 0.
    always_comb begin
        w_side  = side_cond(i_arc);
        w_act   = (i_phase == 2'd1);
        o_drive = 4'b0000;
        case (arc_pin(i_arc))
            2'(PIN_A1): o_drive = {w_side[0], w_side[1], w_side[2], w_act};
            2'(PIN_A2): o_drive = {w_side[0], w_side[1], w_act, w_side[2]};
            2'(PIN_B1): o_drive = {w_side[0], w_act, w_side[1], w_side[2]};
            2'(PIN_B2): o_drive = {w_act, w_side[0], w_side[1], w_side[2]};
        endcase
        o_exp_zn = oai22_zn(o_drive);
    end

endmodule
`default_nettype wire

// File: rtl/oai22_arc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : oai22_arc_sequencer
// Brief    : Walks an OAI22 cell through its 12 conditional arcs and checks ZN
// Revision : 1.0 - initial release
// ============================================================================
module oai22_arc_sequencer
    import oai22_seq_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int CW         = 4
) (
    input  wire logic             CK,
    input  wire logic             RST,
    oai22_arc_sequencer_if.slave  bus
);

    localparam logic [CW-1:0] C_SETTLE_LOAD = CW'(SETTLE_CYC);
    localparam logic [CW-1:0] C_CNT_ONE     = CW'(1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_arc;
    logic [1:0]    r_phase;
    logic [3:0]    r_drive;
    logic          r_exp;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic [4:0]    r_err;
    logic [3:0]    r_fail;

    logic          w_last_phase;
    logic          w_last;
    logic [3:0]    w_nxt_arc;
    logic [1:0]    w_nxt_phase;
    logic [3:0]    w_rom_arc;
    logic [1:0]    w_rom_phase;
    logic [3:0]    w_rom_drive;
    logic          w_rom_exp;
    logic          w_mismatch;
    logic [4:0]    w_err_nxt;
    logic [3:0]    w_fail_nxt;

    assign w_last_phase = (r_phase == 2'(NUM_PHASES - 1));
    assign w_last       = w_last_phase && (r_arc == 4'(NUM_ARCS - 1));
    assign w_nxt_arc    = w_last_phase ? r_arc + 4'd1 : r_arc;
    assign w_nxt_phase  = w_last_phase ? 2'd0 : r_phase + 2'd1;

    // Outside CHECK the only pattern ever loaded is the first one of a run.
    assign w_rom_arc    = (r_state == ST_CHECK) ? w_nxt_arc   : 4'd0;
    assign w_rom_phase  = (r_state == ST_CHECK) ? w_nxt_phase : 2'd0;

    oai22_arc_rom u_rom (
        .i_arc    (w_rom_arc),
        .i_phase  (w_rom_phase),
        .o_drive  (w_rom_drive),
        .o_exp_zn (w_rom_exp)
    );

    assign w_mismatch = (bus.ZN_I != r_exp);
    assign w_err_nxt  = (w_mismatch && (r_err != 5'd31)) ? r_err + 5'd1 : r_err;
    assign w_fail_nxt = (w_mismatch && (r_fail == FAIL_NONE)) ? r_arc : r_fail;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_arc   <= 4'd0;
            r_phase <= 2'd0;
            r_drive <= 4'd0;
            r_exp   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 5'd0;
            r_fail  <= FAIL_NONE;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_drive <= 4'd0;
                    if (bus.START) begin
                        r_state <= ST_SETTLE;
                        r_drive <= w_rom_drive;
                        r_exp   <= w_rom_exp;
                        r_arc   <= 4'd0;
                        r_phase <= 2'd0;
                        r_cnt   <= C_SETTLE_LOAD;
                        r_err   <= 5'd0;
                        r_fail  <= FAIL_NONE;
                        r_pass  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (bus.ABORT) begin
                        r_state <= ST_IDLE;
                        r_drive <= 4'd0;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_ONE;
                        if (r_cnt == C_CNT_ONE) begin
                            r_state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (bus.ABORT) begin
                        r_state <= ST_IDLE;
                        r_drive <= 4'd0;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else begin
                        r_err  <= w_err_nxt;
                        r_fail <= w_fail_nxt;
                        if (w_last) begin
                            // PASS uses the post-compare count so it is valid with DONE.
                            r_state <= ST_FIN;
                            r_drive <= 4'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_nxt == 5'd0);
                        end else begin
                            r_state <= ST_SETTLE;
                            r_drive <= w_rom_drive;
                            r_exp   <= w_rom_exp;
                            r_arc   <= w_nxt_arc;
                            r_phase <= w_nxt_phase;
                            r_cnt   <= C_SETTLE_LOAD;
                        end
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.A1_O     = r_drive[PIN_A1];
    assign bus.A2_O     = r_drive[PIN_A2];
    assign bus.B1_O     = r_drive[PIN_B1];
    assign bus.B2_O     = r_drive[PIN_B2];
    assign bus.BUSY     = r_busy;
    assign bus.DONE     = r_done;
    assign bus.PASS     = r_pass;
    assign bus.ERR_CNT  = r_err;
    assign bus.FAIL_ARC = r_fail;
    assign bus.ARC_IDX  = r_arc;

endmodule
`default_nettype wire

// File: tb/tb_oai22_arc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_oai22_arc_sequencer
// Brief    : Self-checking bench for the OAI22 arc sequencer with a cell model
// Revision : 1.0 - initial release
// ============================================================================
module tb_oai22_arc_sequencer;

    logic CK;
    logic RST;
    int   mode;   // 0 good cell, 1 ZN tied 0, 2 ZN tied 1, 3 B1 stuck at 0
    int   n_checks;
    int   n_errors;

    oai22_arc_sequencer_if bus ();

    oai22_arc_sequencer #(
        .SETTLE_CYC (2),
        .CW         (4)
    ) dut (
        .CK  (CK),
        .RST (RST),
        .bus (bus.slave)
    );

    logic w_b1_eff;
    assign w_b1_eff = (mode == 3) ? 1'b0 : bus.B1_O;
    assign bus.ZN_I = (mode == 1) ? 1'b0 :
                      (mode == 2) ? 1'b1 :
                      ~((bus.A1_O | bus.A2_O) & (w_b1_eff | bus.B2_O));

    initial CK = 1'b0;
    always #5 CK = ~CK;

    typedef struct {
        int         mode;
        int         err;
        int         fail;
        int         pass;
    } run_vec_t;

    run_vec_t   vecs [4];
    logic [3:0] base [12];   // {A1,A2,B1,B2} with the active pin low
    logic [3:0] mask [12];   // active pin

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset();
        check("rst_busy",  int'(bus.BUSY), 0);
        check("rst_done",  int'(bus.DONE), 0);
        check("rst_pass",  int'(bus.PASS), 0);
        check("rst_err",   int'(bus.ERR_CNT), 0);
        check("rst_fail",  int'(bus.FAIL_ARC), 15);
        check("rst_arc",   int'(bus.ARC_IDX), 0);
        check("rst_drive", int'({bus.A1_O, bus.A2_O, bus.B1_O, bus.B2_O}), 0);
    endtask

    // Starts a run and follows it until BUSY drops; returns the BUSY length.
    task automatic run_seq(input int repulse_at, output int busy_cyc);
        int         bad_drv;
        int         k;
        logic [3:0] exp_d;
        logic [3:0] act_d;
        @(negedge CK);
        bus.START = 1'b1;
        @(posedge CK);
        #1;
        bus.START = 1'b0;
        busy_cyc  = 0;
        bad_drv   = 0;
        while (bus.BUSY === 1'b1 && busy_cyc < 400) begin
            k     = busy_cyc / 3;
            act_d = {bus.A1_O, bus.A2_O, bus.B1_O, bus.B2_O};
            if (k < 36) begin
                exp_d = base[k/3] | (((k % 3) == 1) ? mask[k/3] : 4'b0000);
                if (act_d !== exp_d || int'(bus.ARC_IDX) != k / 3) begin
                    if (bad_drv == 0)
                        $display("drive diff at cyc %0d: drive %b arc %0d, want %b arc %0d",
                                 busy_cyc, act_d, bus.ARC_IDX, exp_d, k / 3);
                    bad_drv++;
                end
            end
            bus.START = (busy_cyc == repulse_at);
            @(posedge CK);
            #1;
            busy_cyc++;
        end
        bus.START = 1'b0;
        check("drive_pattern", bad_drv, 0);
    endtask

    initial begin
        int bc;
        int done_seen;
        n_checks = 0;
        n_errors = 0;
        mode     = 0;

        vecs[0] = '{mode: 0, err: 0,  fail: 15, pass: 1};
        vecs[1] = '{mode: 1, err: 24, fail: 0,  pass: 0};
        vecs[2] = '{mode: 2, err: 12, fail: 0,  pass: 0};
        vecs[3] = '{mode: 3, err: 5,  fail: 1,  pass: 0};

        base[0]  = 4'b0001; mask[0]  = 4'b1000;
        base[1]  = 4'b0010; mask[1]  = 4'b1000;
        base[2]  = 4'b0011; mask[2]  = 4'b1000;
        base[3]  = 4'b0001; mask[3]  = 4'b0100;
        base[4]  = 4'b0010; mask[4]  = 4'b0100;
        base[5]  = 4'b0011; mask[5]  = 4'b0100;
        base[6]  = 4'b0100; mask[6]  = 4'b0010;
        base[7]  = 4'b1000; mask[7]  = 4'b0010;
        base[8]  = 4'b1100; mask[8]  = 4'b0010;
        base[9]  = 4'b0100; mask[9]  = 4'b0001;
        base[10] = 4'b1000; mask[10] = 4'b0001;
        base[11] = 4'b1100; mask[11] = 4'b0001;

        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        RST       = 1'b1;
        repeat (3) @(posedge CK);
        @(negedge CK);
        RST = 1'b0;
        #1;
        chk_reset();

        // ABORT in IDLE does nothing
        @(negedge CK);
        bus.ABORT = 1'b1;
        @(posedge CK);
        #1;
        bus.ABORT = 1'b0;
        check("abort_idle_busy", int'(bus.BUSY), 0);

        for (int i = 0; i < 4; i++) begin
            mode = vecs[i].mode;
            run_seq(-1, bc);
            check("busy_cycles", bc, 108);
            check("done_pulse", int'(bus.DONE), 1);
            check("err_cnt", int'(bus.ERR_CNT), vecs[i].err);
            check("fail_arc", int'(bus.FAIL_ARC), vecs[i].fail);
            check("pass", int'(bus.PASS), vecs[i].pass);
            @(posedge CK);
            #1;
            check("done_drop", int'(bus.DONE), 0);
        end

        // START and ABORT together in IDLE: START wins; then abort at cycle 20
        mode = 0;
        @(negedge CK);
        bus.START = 1'b1;
        bus.ABORT = 1'b1;
        @(posedge CK);
        #1;
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        check("start_wins", int'(bus.BUSY), 1);
        repeat (19) @(posedge CK);
        #1;
        bus.ABORT = 1'b1;
        @(posedge CK);
        #1;
        bus.ABORT = 1'b0;
        check("abort_busy", int'(bus.BUSY), 0);
        check("abort_drive", int'({bus.A1_O, bus.A2_O, bus.B1_O, bus.B2_O}), 0);
        check("abort_pass", int'(bus.PASS), 0);
        done_seen = int'(bus.DONE);
        for (int c = 0; c < 10; c++) begin
            @(posedge CK);
            #1;
            if (bus.DONE === 1'b1) done_seen = 1;
        end
        check("abort_no_done", done_seen, 0);

        // Fresh run with START re-pulsed mid-run
        run_seq(50, bc);
        check("repulse_cycles", bc, 108);
        check("repulse_done", int'(bus.DONE), 1);
        check("repulse_pass", int'(bus.PASS), 1);
        repeat (5) @(posedge CK);
        #1;
        check("pass_held", int'(bus.PASS), 1);
        check("idle_busy", int'(bus.BUSY), 0);

        // Asynchronous reset mid-run with ZN tied low
        mode = 1;
        @(negedge CK);
        bus.START = 1'b1;
        @(posedge CK);
        #1;
        bus.START = 1'b0;
        repeat (30) @(posedge CK);
        #1;
        check("mid_err", int'(bus.ERR_CNT), 7);
        check("mid_arc", int'(bus.ARC_IDX), 3);
        #1;
        RST = 1'b1;
        #1;
        chk_reset();
        @(negedge CK);
        RST = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
